systolic_tile_sequencer: RTL and testbench

Top-level controller for the MATRIX_SIZE x MATRIX_SIZE weight-stationary systolic array. On a start request it runs num_tiles back-to-back tiles. Each tile loads weights, streams activations with per-row skewed PE enables, drains the pipeline and flags result rows. It drives the weight buffer, activation buffer and result capture logic, and reports busy/done to the host-side control.

---
 rtl/systolic_pkg.sv | 28 ++
 rtl/systolic_tile_sequencer_if.sv | 35 +++
 rtl/systolic_tile_sequencer_skew_enable_gen.sv | 22 ++
 rtl/systolic_tile_sequencer.sv | 131 +++++++++++++
 tb/tb_systolic_tile_sequencer.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared state encoding and window arithmetic for the systolic tile sequencer
package systolic_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_STREAM = 2'd2,
      ST_FINISH = 2'd3
   } state_t;

   // Last stream count: activations enter for N cycles, the last row is skewed
   // by N-1 cycles and the pipeline needs PE_LATENCY more to drain.
   function automatic int last_cnt(input int n, input int lat);
      return 2 * n + lat - 2;
   endfunction

   // First stream count carrying a result row; the window closes at last_cnt,
   // so exactly N rows are flagged and result_row always fits the row index.
   function automatic int result_start(input int n, input int lat);
      return n + lat - 1;
   endfunction

   // Width of the shared load/stream counter.
   function automatic int cnt_width(input int n, input int lat);
      return $clog2(last_cnt(n, lat) + 1);
   endfunction

endpackage

// File: rtl/systolic_tile_sequencer_if.sv
// rtl/systolic_tile_sequencer_if.sv - host control and array strobe bundle for the tile sequencer
interface systolic_tile_sequencer_if #(
   parameter int N      = 2,
   parameter int TILE_W = 8
);
   localparam int AW = $clog2(N);

   logic              en;
   logic              start;
   logic [TILE_W-1:0] num_tiles;
   logic              busy;
   logic              done;
   logic              load_weight;
   logic [AW-1:0]     weight_row_addr;
   logic              act_valid;
   logic [AW-1:0]     act_rd_addr;
   logic [N-1:0]      enable_mult;
   logic              result_valid;
   logic [AW-1:0]     result_row;
   logic [TILE_W-1:0] tile_idx;

   // Host / environment side
   modport master (
      output en, start, num_tiles,
      input  busy, done, load_weight, weight_row_addr, act_valid, act_rd_addr,
             enable_mult, result_valid, result_row, tile_idx
   );

   // Sequencer side
   modport slave (
      input  en, start, num_tiles,
      output busy, done, load_weight, weight_row_addr, act_valid, act_rd_addr,
             enable_mult, result_valid, result_row, tile_idx
   );
endinterface

// File: rtl/systolic_tile_sequencer_skew_enable_gen.sv
// rtl/systolic_tile_sequencer_skew_enable_gen.sv - diagonal per-row PE enable window decode
module skew_enable_gen #(
   parameter int N          = 2,
   parameter int PE_LATENCY = 4,
   parameter int CW         = 3
) (
   input  logic [CW-1:0] i_cnt,
   input  logic          i_en,
   output logic [N-1:0]  o_enable_mult
);
   logic [31:0] w_cnt;

   assign w_cnt = 32'(i_cnt);

   // Row i is live from count i for N+PE_LATENCY cycles (skewed by its row index)
   always_comb begin
      o_enable_mult = '0;
      for (int i = 0; i < N; i++) begin
         o_enable_mult[i] = i_en && (w_cnt >= 32'(i)) && (w_cnt <= 32'(i + N - 1 + PE_LATENCY));
      end
   end
endmodule

// File: rtl/systolic_tile_sequencer.sv
// rtl/systolic_tile_sequencer.sv - multi-tile load/stream/drain sequencer for the systolic array
module systolic_tile_sequencer
   import systolic_pkg::*;
#(
   parameter int MATRIX_SIZE = 2,
   parameter int PE_LATENCY  = 4,
   parameter int TILE_W      = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   systolic_tile_sequencer_if.slave bus
);
   localparam int N    = MATRIX_SIZE;
   localparam int AW   = $clog2(N);
   localparam int CW   = cnt_width(N, PE_LATENCY);
   localparam int LAST = last_cnt(N, PE_LATENCY);
   localparam int RS   = result_start(N, PE_LATENCY);

   localparam logic [CW-1:0] C_LOAD_END = CW'(N - 1);
   localparam logic [CW-1:0] C_LAST     = CW'(LAST);
   localparam logic [CW-1:0] C_ACT_END  = CW'(N);
   localparam logic [CW-1:0] C_RES      = CW'(RS);

   state_t            r_state, w_state_nx;
   logic [CW-1:0]     r_cnt, w_cnt_nx;
   logic [TILE_W-1:0] r_tile_idx, w_tile_nx;
   logic [TILE_W-1:0] r_num_tiles, w_num_nx;
   logic              r_zero_job, w_zero_nx;

   logic              w_is_load, w_is_stream, w_is_finish;
   logic              w_act_win, w_res_win;
   logic [CW-1:0]     w_res_off;

   // State and counter registers; everything clears asynchronously
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_tile_idx  <= '0;
         r_num_tiles <= '0;
         r_zero_job  <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_cnt       <= w_cnt_nx;
         r_tile_idx  <= w_tile_nx;
         r_num_tiles <= w_num_nx;
         r_zero_job  <= w_zero_nx;
      end
   end

   // Next-state logic; with en low nothing advances, which also defers done
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_tile_nx  = r_tile_idx;
      w_num_nx   = r_num_tiles;
      w_zero_nx  = r_zero_job;
      if (bus.en) begin
         unique case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  w_num_nx  = bus.num_tiles;
                  w_tile_nx = '0;
                  w_cnt_nx  = '0;
                  if (bus.num_tiles == '0) begin
                     w_state_nx = ST_FINISH;
                     w_zero_nx  = 1'b1;
                  end else begin
                     w_state_nx = ST_LOAD;
                     w_zero_nx  = 1'b0;
                  end
               end
            end
            ST_LOAD: begin
               if (r_cnt == C_LOAD_END) begin
                  w_cnt_nx   = '0;
                  w_state_nx = ST_STREAM;
               end else begin
                  w_cnt_nx = r_cnt + 1'b1;
               end
            end
            ST_STREAM: begin
               if (r_cnt == C_LAST) begin
                  w_cnt_nx = '0;
                  if (({1'b0, r_tile_idx} + 1'b1) < {1'b0, r_num_tiles}) begin
                     w_tile_nx  = r_tile_idx + 1'b1;
                     w_state_nx = ST_LOAD;
                  end else begin
                     w_state_nx = ST_FINISH;
                  end
               end else begin
                  w_cnt_nx = r_cnt + 1'b1;
               end
            end
            ST_FINISH: begin
               w_state_nx = ST_IDLE;
               w_zero_nx  = 1'b0;
            end
            default: w_state_nx = ST_IDLE;
         endcase
      end
   end

   assign w_is_load   = (r_state == ST_LOAD);
   assign w_is_stream = (r_state == ST_STREAM);
   assign w_is_finish = (r_state == ST_FINISH);
   assign w_act_win   = w_is_stream && (r_cnt < C_ACT_END);
   assign w_res_win   = w_is_stream && (r_cnt >= C_RES);
   assign w_res_off   = r_cnt - C_RES;

   // Strobes are gated by en; addresses, busy and tile_idx only follow registered state
   assign bus.load_weight     = w_is_load & bus.en;
   assign bus.weight_row_addr = w_is_load ? r_cnt[AW-1:0] : '0;
   assign bus.act_valid       = w_act_win & bus.en;
   assign bus.act_rd_addr     = w_act_win ? r_cnt[AW-1:0] : '0;
   assign bus.result_valid    = w_res_win & bus.en;
   assign bus.result_row      = w_res_win ? w_res_off[AW-1:0] : '0;
   assign bus.busy            = w_is_load | w_is_stream | (w_is_finish & r_zero_job);
   assign bus.done            = w_is_finish & bus.en;
   assign bus.tile_idx        = r_tile_idx;

   skew_enable_gen #(
      .N          (N),
      .PE_LATENCY (PE_LATENCY),
      .CW         (CW)
   ) u_skew (
      .i_cnt         (r_cnt),
      .i_en          (w_is_stream & bus.en),
      .o_enable_mult (bus.enable_mult)
   );
endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// tb/tb_systolic_tile_sequencer.sv - self-checking bench for systolic_tile_sequencer
module tb_systolic_tile_sequencer;
   localparam int N  = 2;
   localparam int PL = 4;
   localparam int TW = 8;
   localparam int AW = $clog2(N);
   localparam int P  = 3 * N + PL - 1;
   localparam int RS = N + PL - 1;

   logic clk = 1'b0;
   logic reset;
   int   n_vec = 0;
   int   n_err = 0;
   int   last_tile = 0;

   systolic_tile_sequencer_if #(.N(N), .TILE_W(TW)) bus ();

   systolic_tile_sequencer #(
      .MATRIX_SIZE (N),
      .PE_LATENCY  (PL),
      .TILE_W      (TW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] pack(input logic b, input logic d, input logic lw,
                                        input logic [AW-1:0] wra, input logic av,
                                        input logic [AW-1:0] ara, input logic [N-1:0] em,
                                        input logic rv, input logic [AW-1:0] rr,
                                        input logic [TW-1:0] t);
      return 64'({b, d, lw, wra, av, ara, em, rv, rr, t});
   endfunction

   function automatic logic [63:0] obs();
      return pack(bus.busy, bus.done, bus.load_weight, bus.weight_row_addr, bus.act_valid,
                  bus.act_rd_addr, bus.enable_mult, bus.result_valid, bus.result_row, bus.tile_idx);
   endfunction

   // Reference: pos = enabled edges since the start edge (0 = idle); each tile is
   // N load cycles followed by a stream phase s = 0..2N+PL-2.
   function automatic logic [63:0] model(input int num, input int pos, input logic e);
      logic b = 0, d = 0, lw = 0, av = 0, rv = 0;
      int   wra = 0, ara = 0, rr = 0, t = last_tile, k, ph, s;
      logic [N-1:0] em = '0;
      if (pos == 0) begin
         t = last_tile;
      end else if (num == 0) begin
         b = 1; d = e; t = 0;
      end else if (pos <= num * P) begin
         k = pos - 1; t = k / P; ph = k % P; b = 1;
         if (ph < N) begin
            lw = e; wra = ph;
         end else begin
            s = ph - N;
            if (s < N) begin av = e; ara = s; end
            for (int i = 0; i < N; i++) em[i] = e && (s >= i) && (s <= i + N - 1 + PL);
            if (s >= RS) begin rv = e; rr = s - RS; end
         end
      end else begin
         d = e; t = num - 1;
      end
      return pack(b, d, lw, AW'(wra), av, AW'(ara), em, rv, AW'(rr), TW'(t));
   endfunction

   // Entered and left just after a rising edge with the DUT in IDLE
   task automatic run_job(input int num, input bit keep_start, input bit rnd,
                          input int stall_at, input int stall_len);
      int pos, final_pos, cyc, stalled;
      logic e;
      final_pos = (num == 0) ? 1 : num * P + 1;
      bus.num_tiles = TW'(num);
      bus.start = 1'b1;
      bus.en = 1'b1;
      @(negedge clk);
      check_eq("idle", obs(), model(num, 0, 1'b1));
      @(posedge clk); #1;
      if (!keep_start) bus.start = 1'b0;
      last_tile = 0; pos = 1; cyc = 1; stalled = 0;
      while (1) begin
         if (pos == stall_at && stalled < stall_len) begin e = 1'b0; stalled++; end
         else if (rnd) e = ($urandom_range(0, 3) != 0);
         else e = 1'b1;
         bus.en = e;
         @(negedge clk);
         check_eq("cycle", obs(), model(num, pos, e));
         @(posedge clk); #1;
         if (e) begin
            if (pos == final_pos) break;
            pos++;
         end
         cyc++;
         if (cyc > 2000) begin
            check_eq("job_bound", 64'(cyc), 64'(2000));
            break;
         end
      end
      bus.en = 1'b1;
      last_tile = (num == 0) ? 0 : num - 1;
      if (!rnd) check_eq("done_cycle", 64'(cyc), 64'(final_pos + stall_len));
   endtask

   initial begin
      reset = 1'b1;
      bus.en = 1'b0;
      bus.start = 1'b0;
      bus.num_tiles = '0;
      #2;
      check_eq("reset_outputs", obs(), 64'(0));
      repeat (2) @(posedge clk);
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;

      // start with en low is not accepted
      bus.start = 1'b1; bus.en = 1'b0; bus.num_tiles = 8'd1;
      @(negedge clk); check_eq("start_no_en", obs(), model(1, 0, 1'b0));
      @(posedge clk); #1;
      bus.start = 1'b0; bus.en = 1'b1;
      @(negedge clk); check_eq("still_idle", obs(), model(1, 0, 1'b1));
      @(posedge clk); #1;

      run_job(1, 1'b0, 1'b0, 0, 0);
      run_job(3, 1'b0, 1'b0, 0, 0);
      // stall at stream cnt=4 (pos = N + 4 + 1)
      run_job(1, 1'b0, 1'b0, N + 5, 3);
      run_job(0, 1'b0, 1'b0, 0, 0);
      // start held through a job; the next job starts in the following IDLE cycle
      run_job(2, 1'b1, 1'b0, 0, 0);
      run_job(1, 1'b0, 1'b0, 0, 0);

      // asynchronous reset mid-stream at cnt=5
      bus.num_tiles = 8'd1; bus.start = 1'b1; bus.en = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int p = 1; p < N + 6; p++) @(posedge clk);
      #1;
      @(negedge clk); check_eq("pre_reset", obs(), model(1, N + 6, 1'b1));
      #2 reset = 1'b1;
      #1 check_eq("async_reset", obs(), 64'(0));
      @(posedge clk);
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;
      last_tile = 0;
      run_job(1, 1'b0, 1'b0, 0, 0);

      // randomized jobs with random en stalls
      for (int j = 0; j < 20; j++) begin
         run_job($urandom_range(0, 4), bit'($urandom_range(0, 1)), 1'b1, 0, 0);
      end
      bus.start = 1'b0;
      @(negedge clk); check_eq("final_idle", obs(), model(0, 0, 1'b1));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
